// File: rtl/bomberman_sprite_render.sv
// bomberman_sprite_render: 16x16 player sprite renderer that addresses the sprite ROM and keys/mirrors/bobs the returned pixel.
// Ports: clk/reset_n (sync, active-low); video_on, x, y scan position; frame_tick vblank pulse;
//   player_x/player_y/move_dir player request; rom_row/rom_col ROM address out, rom_color ROM data in (1-cycle latency);
//   rgb_out/sprite_on registered pixel, 2 clk after x/y.
// Optional: define BOUNDING_BOX_DEBUG_EN to paint the sprite border in DEBUG_COLOR.
module bomberman_sprite_render #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter logic [11:0] TRANSPARENT = 12'hFFF,
  parameter int ANIM_DIV = 8
`ifdef BOUNDING_BOX_DEBUG_EN
  , parameter logic [11:0] DEBUG_COLOR = 12'hF00
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [2:0]  move_dir,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic [11:0] rgb_out,
  output logic        sprite_on
);
  localparam int AW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  typedef enum logic {IDLE, WALK} state_t;
  state_t state, state_n;
  logic [AW-1:0] anim_cnt, cnt_n;
  logic phase, phase_n, facing, wrap;
  logic [9:0] pos_x, pos_y, ey;
  logic [3:0] dx, dy;
  logic hit, hit_d, opaque;
  // bob lifts the sprite one row in phase 1, but never above row 0
  assign ey = pos_y - {9'd0, phase & (pos_y != 10'd0)};
  // reset_n gates hit so the ROM address reads 0 while held in reset
  assign hit = reset_n & video_on
             & ({1'b0, x} >= {1'b0, pos_x}) & ({1'b0, x} < {1'b0, pos_x} + 11'(SPRITE_W))
             & ({1'b0, y} >= {1'b0, ey}) & ({1'b0, y} < {1'b0, ey} + 11'(SPRITE_H));
  assign dx = x[3:0] - pos_x[3:0];
  assign dy = y[3:0] - ey[3:0];
  // facing=1 means left; 15-dx is the bitwise inverse in 4 bits
  assign rom_col = hit ? {1'b0, facing ? ~dx : dx} : 5'd0;
  assign rom_row = hit ? {phase, dy} : 5'd0;
  assign opaque = hit_d & (rom_color != TRANSPARENT);
  assign wrap = anim_cnt == AW'(ANIM_DIV - 1);
  always_comb begin
    state_n = state;
    cnt_n = anim_cnt;
    phase_n = phase;
    if (frame_tick && state == IDLE) state_n = move_dir[2] ? WALK : IDLE;
    else if (frame_tick && !move_dir[2]) begin
      state_n = IDLE;
      cnt_n = '0;
      phase_n = 1'b0;
    end else if (frame_tick) begin
      cnt_n = wrap ? '0 : anim_cnt + AW'(1);
      phase_n = phase ^ wrap;
    end
  end
`ifdef BOUNDING_BOX_DEBUG_EN
  logic edge_d;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_d <= 1'b0;
      sprite_on <= 1'b0;
      rgb_out <= 12'd0;
    end else begin
      edge_d <= hit & ((dx == 4'd0) | (&dx) | (dy == 4'd0) | (&dy));
      sprite_on <= edge_d | opaque;
      rgb_out <= edge_d ? DEBUG_COLOR : opaque ? rom_color : 12'd0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sprite_on <= 1'b0;
      rgb_out <= 12'd0;
    end else begin
      sprite_on <= opaque;
      rgb_out <= opaque ? rom_color : 12'd0;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      anim_cnt <= '0;
      phase <= 1'b0;
      facing <= 1'b0;
      pos_x <= 10'd0;
      pos_y <= 10'd0;
      hit_d <= 1'b0;
    end else begin
      state <= state_n;
      anim_cnt <= cnt_n;
      phase <= phase_n;
      hit_d <= hit;
      if (frame_tick) begin
        pos_x <= player_x;
        pos_y <= player_y;
        if (move_dir[2] & move_dir[1]) facing <= ~move_dir[0];
      end
    end
  end
endmodule

// File: doc/bomberman_sprite_render.md
Name: bomberman_sprite_render

Overview:
Upstream/downstream companion of the 16x16 player sprite ROM. It takes the VGA pixel coordinate stream and the player position/motion, generates the ROM row/col address, and consumes the returned 12-bit colour one cycle later. It applies transparency keying, horizontal mirroring and a walk-bob animation. Its output is a registered RGB pixel plus a sprite_on flag for the top-level pixel mux.

Parameters:
SPRITE_W, 16, sprite width in pixels (ROM column count)
SPRITE_H, 16, sprite height in pixels (ROM row count)
TRANSPARENT, 12'hFFF, ROM colour treated as see-through
ANIM_DIV, 8, frame_ticks per animation phase toggle while walking
DEBUG_COLOR, 12'hF00, bounding-box colour (optional feature only)

Ports:
clk  in  1  system pixel clock
reset_n  in  1  synchronous, active-low reset
video_on  in  1  high during the visible area
x  in  10  current pixel column, 0..639
y  in  10  current pixel row, 0..479
frame_tick  in  1  one-cycle pulse at the start of vertical blank
player_x  in  10  sprite top-left column request
player_y  in  10  sprite top-left row request
move_dir  in  3  {valid, dir[1:0]}; dir 00=up, 01=down, 10=left, 11=right
rom_row  out  5  address to the sprite ROM; bit4 = anim phase
rom_col  out  5  address to the sprite ROM; bit4 = 0
rom_color  in  12  ROM colour, valid one cycle after the address
rgb_out  out  12  registered sprite pixel colour
sprite_on  out  1  registered; high when rgb_out is an opaque sprite pixel

Behaviour:
- Reset (reset_n=0 at a clk edge): rgb_out=0, sprite_on=0, pos_x/pos_y regs=0, facing=right, state=IDLE, anim_cnt=0, phase=0, hit pipeline regs=0. A reset during an active line overrides everything, including a same-cycle frame_tick.
- Position latch: pos_x/pos_y update from player_x/player_y only on frame_tick. No mid-frame tearing.
- Facing: on frame_tick with move_dir valid and dir=10 -> facing=left. With dir=11 -> facing=right. Up/down leave facing unchanged.
- FSM:
  - IDLE -> WALK on frame_tick with move_dir valid.
  - WALK -> IDLE on frame_tick with move_dir not valid; this clears anim_cnt and phase.
  - In WALK each frame_tick increments anim_cnt. When anim_cnt==ANIM_DIV-1 it wraps to 0 and phase toggles.
- Bob: effective top row ey = pos_y - phase (1-pixel lift in phase 1). When pos_y=0 and phase=1, ey saturates at 0.
- Hit test (combinational, 11-bit compares, no wrap):
  - hit = video_on & x>=pos_x & x<pos_x+SPRITE_W & y>=ey & y<ey+SPRITE_H.
  - A sprite extending past 639/479 is clipped naturally.
- Address:
  - dy = y-ey.
  - dx = x-pos_x.
  - rom_col = facing left ? 15-dx : dx.
  - rom_row = {phase, dy[3:0]}.
  - When hit=0, the address is don't-care and driven 0.
- Pipeline:
  - Stage 1: hit_d <= hit (aligned with the ROM's internal address register).
  - Stage 2: sprite_on <= hit_d & (rom_color != TRANSPARENT); rgb_out <= that ? rom_color : 0.
  - Total latency x/y -> rgb_out/sprite_on = 2 clk. The top-level delays its background path by 2.
- frame_tick coinciding with a visible pixel: the new position applies from the next cycle; the current pixel uses the old position.

Optional Feature:
BOUNDING_BOX_DEBUG_EN: when defined, pixels with hit=1 and dx or dy equal to 0 or 15 force sprite_on=1 and rgb_out=DEBUG_COLOR (same 2-cycle latency), ignoring transparency. When undefined, there is no debug logic and DEBUG_COLOR is unused.

Test Plan:
- reset_n=0 for 3 clk with video_on=1 over the sprite -> rgb_out=0, sprite_on=0, rom_row/col=0.
- player_x=100, player_y=50, frame_tick, scan x=107,y=54 -> rom_row=4, rom_col=7; 2 clk later rgb_out=12'hB97, sprite_on=1.
- Same position, x=100,y=50 (ROM returns 12'hFFF) -> sprite_on=0, rgb_out=0. x=99 -> hit=0.
- move_dir=3'b110 on frame_tick, scan x=100,y=54 -> rom_col=15, rom_row=4.
- move_dir=3'b111 held for 8 frame_ticks -> phase=1. Pixel y=49,x=103 hits with rom_row=5'b10000, rom_col=3. Drop valid + frame_tick -> IDLE, phase=0.
- player_x=630: x=639 hits with rom_col=9; x wraps to 0 on the next line with no hit. With BOUNDING_BOX_DEBUG_EN, x=630,y=54 -> rgb_out=12'hF00.
